// File: rtl/fifo_pkg.sv
// Shared definitions for the synchronous FIFO, its read-side streamer and their benches.
// Holds the FIFO geometry and a sizing helper for the streamer's skid buffer.
package fifo_pkg;

  localparam int FIFO_DW         = 8;
  localparam int FIFO_DEPTH      = 16;
  localparam int FIFO_RD_LATENCY = 1;

  // Bits needed to hold an occupancy count of 0..depth inclusive.
  function automatic int skid_cnt_w(input int depth);
    return $clog2(depth + 1);
  endfunction

endpackage

// File: rtl/fifo_skid_buf.sv
// Small circular skid buffer: register array with head/tail pointers and an occupancy count.
// Pointers wrap by explicit compare so any depth >= 2 works, not only powers of two.
module fifo_skid_buf
  import fifo_pkg::*;
#(
  parameter int  DW         = FIFO_DW,
  parameter int  SKID_DEPTH = 3,
  localparam int PTR_W      = (SKID_DEPTH > 1) ? $clog2(SKID_DEPTH) : 1,
  localparam int CNT_W      = skid_cnt_w(SKID_DEPTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic [DW-1:0]    push_data,
  input  logic             pop,
  output logic [DW-1:0]    head_data,
  output logic [CNT_W-1:0] count
);

  localparam logic [PTR_W-1:0] LAST_PTR = PTR_W'(SKID_DEPTH - 1);
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(SKID_DEPTH);

  logic [DW-1:0]    mem [SKID_DEPTH];
  logic [PTR_W-1:0] head;
  logic [PTR_W-1:0] tail;
  logic             do_pop;

  function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] p);
    return (p == LAST_PTR) ? '0 : p + PTR_W'(1);
  endfunction

  assign do_pop    = pop && (count != '0);
  assign head_data = mem[head];

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else begin
      if (push)   tail <= next_ptr(tail);
      if (do_pop) head <= next_ptr(head);
      case ({push, do_pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

  // NOTE: the storage array is deliberately not reset; count and pointers alone decide which entries are live.
  always_ff @(posedge clk) begin
    if (push) mem[tail] <= push_data;
  end

  // The read-issue credit rule must never let a word land in a full buffer.
  assert property (@(posedge clk) disable iff (!rst_n) !(push && !do_pop && count == FULL_CNT));

endmodule

// File: rtl/fifo_read_streamer.sv
// Read-side engine for the synchronous FIFO: issues credit-limited reads and re-presents
// the returned words as a valid/ready stream through a skid buffer.
module fifo_read_streamer
  import fifo_pkg::*;
#(
  parameter int DW         = FIFO_DW,
  parameter int SKID_DEPTH = 3,
  parameter int CNT_W      = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic             fifo_empty,
  input  logic             fifo_underflow,
  input  logic [DW-1:0]    fifo_rdata,
  output logic             fifo_rd,
  output logic             m_valid,
  input  logic             m_ready,
  output logic [DW-1:0]    m_data,
  output logic [CNT_W-1:0] word_count,
  output logic             err_underflow,
  output logic             idle
);

  localparam int SC_W = skid_cnt_w(SKID_DEPTH);

  logic [SC_W-1:0] skid_cnt;
  logic [SC_W:0]   credit_used;
  logic [DW-1:0]   head_data;
  logic            inflight;
  logic            pop;

  // A read is only issued when the word it returns is guaranteed a free skid slot;
  // m_ready is intentionally absent so there is no combinational ready->rd path.
  assign credit_used = {1'b0, skid_cnt} + {{SC_W{1'b0}}, inflight};
  assign fifo_rd     = en & ~fifo_empty & (credit_used < (SC_W + 1)'(SKID_DEPTH));

  // Gating keeps m_data at zero whenever the (unreset) storage holds no live word.
  assign m_valid = (skid_cnt != '0);
  assign m_data  = m_valid ? head_data : '0;
  assign pop     = m_valid & m_ready;
  assign idle    = ~m_valid & ~inflight;

  fifo_skid_buf #(
    .DW         (DW),
    .SKID_DEPTH (SKID_DEPTH)
  ) u_skid (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (inflight),
    .push_data (fifo_rdata),
    .pop       (pop),
    .head_data (head_data),
    .count     (skid_cnt)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      inflight      <= 1'b0;
      word_count    <= '0;
      err_underflow <= 1'b0;
    end else begin
      inflight <= fifo_rd;
      if (pop)            word_count    <= word_count + CNT_W'(1);
      if (fifo_underflow) err_underflow <= 1'b1;
    end
  end

endmodule

// File: tb/tb_fifo_read_streamer.sv
// Bench for fifo_read_streamer: a behavioural 16-deep FIFO feeds the streamer and a queue
// of every word written into the FIFO is the in-order delivery reference.
module tb_fifo_read_streamer;
  import fifo_pkg::*;

  localparam int DW = FIFO_DW;
  localparam int FD = FIFO_DEPTH;
  localparam int CW = 16;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          en = 1'b0;
  logic          m_ready = 1'b0;
  logic          fifo_empty;
  logic          fifo_underflow;
  logic [DW-1:0] fifo_rdata;
  logic          fifo_rd;
  logic          m_valid;
  logic [DW-1:0] m_data;
  logic [CW-1:0] word_count;
  logic          err_underflow;
  logic          idle;

  logic          wr = 1'b0;
  logic [DW-1:0] wdata = '0;
  logic          tb_rd = 1'b0;

  always #5 clk = ~clk;

  fifo_read_streamer #(.DW(DW), .SKID_DEPTH(3), .CNT_W(CW)) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .en             (en),
    .fifo_empty     (fifo_empty),
    .fifo_underflow (fifo_underflow),
    .fifo_rdata     (fifo_rdata),
    .fifo_rd        (fifo_rd),
    .m_valid        (m_valid),
    .m_ready        (m_ready),
    .m_data         (m_data),
    .word_count     (word_count),
    .err_underflow  (err_underflow),
    .idle           (idle)
  );

  // Behavioural FIFO: 1-cycle read latency, one-cycle UNDERFLOW pulse on a read of an empty FIFO.
  logic [DW-1:0] fmem [FD];
  int            fwp, frp, fcnt;
  logic          frd, ffull;

  assign frd        = fifo_rd | tb_rd;
  assign fifo_empty = (fcnt == 0);
  assign ffull      = (fcnt == FD);

  always @(posedge clk) begin
    if (!rst_n) begin
      fwp <= 0; frp <= 0; fcnt <= 0;
      fifo_underflow <= 1'b0;
      fifo_rdata     <= '0;
    end else begin
      fifo_underflow <= frd && fifo_empty;
      if (frd && !fifo_empty) begin
        fifo_rdata <= fmem[frp];
        frp <= (frp + 1) % FD;
      end
      if (wr && !ffull) begin
        fmem[fwp] <= wdata;
        fwp <= (fwp + 1) % FD;
      end
      fcnt <= fcnt + ((wr && !ffull) ? 1 : 0) - ((frd && !fifo_empty) ? 1 : 0);
    end
  end

  // Reference: every word accepted by the FIFO must come out once, in order.
  logic [DW-1:0] exp_q [$];
  int            model_cnt = 0;
  int            n_checks = 0;
  int            n_fail = 0;
  int            rd_pulses = 0;
  logic          prev_stall = 1'b0;
  logic [DW-1:0] prev_data = '0;

  always @(negedge clk) begin
    if (rst_n) begin
      if (fifo_rd) begin
        rd_pulses++;
        n_checks++;
        if (fifo_empty) begin
          n_fail++;
          $display("FAIL rd_on_empty: fifo_rd=1 with fifo_empty=1 at %0t", $time);
        end
      end
      if (prev_stall) begin
        n_checks++;
        if (m_valid !== 1'b1 || m_data !== prev_data) begin
          n_fail++;
          $display("FAIL hold: m_valid=%b m_data=%0h, required 1/%0h", m_valid, m_data, prev_data);
        end
      end
      if (m_valid === 1'b1 && m_ready) begin
        n_checks++;
        if (word_count !== CW'(model_cnt)) begin
          n_fail++;
          $display("FAIL sb_count: word_count=%0d required %0d", word_count, model_cnt);
        end
        n_checks++;
        if (exp_q.size() == 0) begin
          n_fail++;
          $display("FAIL sb_extra: unexpected word %0h delivered", m_data);
        end else begin
          logic [DW-1:0] e;
          e = exp_q.pop_front();
          if (m_data !== e) begin
            n_fail++;
            $display("FAIL sb_data: m_data=%0h required %0h", m_data, e);
          end
        end
        model_cnt++;
      end
      prev_stall = (m_valid === 1'b1) && !m_ready;
      prev_data  = m_data;
    end else begin
      prev_stall = 1'b0;
    end
  end

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  task automatic do_reset(input int cycles);
    m_ready = 1'b0; en = 1'b0; wr = 1'b0; tb_rd = 1'b0;
    rst_n = 1'b0;
    repeat (cycles) step();
    rst_n = 1'b1;
    exp_q.delete();
    model_cnt = 0;
    rd_pulses = 0;
  endtask

  task automatic preload(input logic [DW-1:0] start, input int n);
    for (int i = 0; i < n; i++) begin
      wr = 1'b1;
      wdata = start + DW'(i);
      exp_q.push_back(wdata);
      step();
    end
    wr = 1'b0;
  endtask

  task automatic wait_drain(input int budget, input string name);
    int k;
    k = 0;
    while (!(exp_q.size() == 0 && idle === 1'b1) && k < budget) begin
      step();
      k++;
    end
    n_checks++;
    if (k >= budget) begin
      n_fail++;
      $display("FAIL %s_timeout: %0d words still expected after %0d cycles", name, exp_q.size(), budget);
    end
  endtask

  task automatic test_reset();
    do_reset(2);
    n_checks++; if (fifo_rd !== 1'b0)       begin n_fail++; $display("FAIL reset_rd: got %b required 0", fifo_rd); end
    n_checks++; if (m_valid !== 1'b0)       begin n_fail++; $display("FAIL reset_valid: got %b required 0", m_valid); end
    n_checks++; if (m_data !== '0)          begin n_fail++; $display("FAIL reset_data: got %0h required 0", m_data); end
    n_checks++; if (word_count !== '0)      begin n_fail++; $display("FAIL reset_count: got %0d required 0", word_count); end
    n_checks++; if (err_underflow !== 1'b0) begin n_fail++; $display("FAIL reset_err: got %b required 0", err_underflow); end
    n_checks++; if (idle !== 1'b1)          begin n_fail++; $display("FAIL reset_idle: got %b required 1", idle); end
  endtask

  task automatic test_stream();
    do_reset(1);
    preload(8'h01, 16);
    m_ready = 1'b1;
    en = 1'b1;
    n_checks++; if (m_valid !== 1'b0) begin n_fail++; $display("FAIL lat_t0: m_valid=%b required 0", m_valid); end
    step();
    n_checks++; if (m_valid !== 1'b0) begin n_fail++; $display("FAIL lat_t1: m_valid=%b required 0", m_valid); end
    step();
    n_checks++;
    if (m_valid !== 1'b1 || m_data !== 8'h01) begin
      n_fail++; $display("FAIL lat_t2: m_valid=%b m_data=%0h required 1/01", m_valid, m_data);
    end
    for (int i = 1; i < 16; i++) begin
      step();
      n_checks++;
      if (m_valid !== 1'b1) begin n_fail++; $display("FAIL stream_gap: word %0d m_valid=%b required 1", i, m_valid); end
    end
    wait_drain(20, "stream");
    n_checks++; if (word_count !== CW'(16)) begin n_fail++; $display("FAIL stream_count: got %0d required 16", word_count); end
    n_checks++; if (idle !== 1'b1)          begin n_fail++; $display("FAIL stream_idle: got %b required 1", idle); end
  endtask

  task automatic test_backpressure();
    do_reset(1);
    preload(8'h01, 16);
    rd_pulses = 0;
    en = 1'b1;
    repeat (10) step();
    n_checks++; if (rd_pulses != 3)      begin n_fail++; $display("FAIL bp_rd_pulses: got %0d required 3", rd_pulses); end
    n_checks++; if (m_valid !== 1'b1)    begin n_fail++; $display("FAIL bp_valid: got %b required 1", m_valid); end
    n_checks++; if (m_data !== 8'h01)    begin n_fail++; $display("FAIL bp_data: got %0h required 01", m_data); end
    m_ready = 1'b1;
    for (int i = 1; i < 16; i++) begin
      step();
      n_checks++;
      if (m_valid !== 1'b1) begin n_fail++; $display("FAIL bp_gap: word %0d m_valid=%b required 1", i, m_valid); end
    end
    wait_drain(20, "bp");
    n_checks++; if (word_count !== CW'(16)) begin n_fail++; $display("FAIL bp_count: got %0d required 16", word_count); end
  endtask

  task automatic test_en_drop();
    int k;
    do_reset(1);
    preload(8'h01, 16);
    m_ready = 1'b1;
    rd_pulses = 0;
    en = 1'b1;
    k = 0;
    while (rd_pulses < 5 && k < 20) begin
      step();
      k++;
    end
    en = 1'b0;
    repeat (8) step();
    n_checks++; if (rd_pulses != 5)        begin n_fail++; $display("FAIL en_rd_pulses: got %0d required 5", rd_pulses); end
    n_checks++; if (word_count !== CW'(5)) begin n_fail++; $display("FAIL en_count: got %0d required 5", word_count); end
    n_checks++; if (idle !== 1'b1)         begin n_fail++; $display("FAIL en_idle: got %b required 1", idle); end
    en = 1'b1;
    k = 0;
    while (m_valid !== 1'b1 && k < 10) begin
      step();
      k++;
    end
    n_checks++; if (m_data !== 8'h06) begin n_fail++; $display("FAIL en_resume: m_data=%0h required 06", m_data); end
    wait_drain(30, "en");
    n_checks++; if (word_count !== CW'(16)) begin n_fail++; $display("FAIL en_total: got %0d required 16", word_count); end
  endtask

  task automatic test_underflow();
    do_reset(1);
    tb_rd = 1'b1;
    step();
    tb_rd = 1'b0;
    repeat (3) step();
    n_checks++; if (err_underflow !== 1'b1) begin n_fail++; $display("FAIL uf_set: got %b required 1", err_underflow); end
    repeat (5) step();
    n_checks++; if (err_underflow !== 1'b1) begin n_fail++; $display("FAIL uf_sticky: got %b required 1", err_underflow); end
    do_reset(1);
    n_checks++; if (err_underflow !== 1'b0) begin n_fail++; $display("FAIL uf_clear: got %b required 0", err_underflow); end
  endtask

  task automatic test_reset_full();
    do_reset(1);
    preload(8'h30, 12);
    m_ready = 1'b1;
    en = 1'b1;
    repeat (5) step();
    m_ready = 1'b0;
    repeat (6) step();
    n_checks++; if (m_valid !== 1'b1)           begin n_fail++; $display("FAIL rf_valid_before: got %b required 1", m_valid); end
    n_checks++; if (word_count !== CW'(model_cnt)) begin n_fail++; $display("FAIL rf_count_before: got %0d required %0d", word_count, model_cnt); end
    do_reset(1);
    n_checks++; if (m_valid !== 1'b0)      begin n_fail++; $display("FAIL rf_valid: got %b required 0", m_valid); end
    n_checks++; if (word_count !== '0)     begin n_fail++; $display("FAIL rf_count: got %0d required 0", word_count); end
    n_checks++; if (idle !== 1'b1)         begin n_fail++; $display("FAIL rf_idle: got %b required 1", idle); end
    preload(8'hA0, 4);
    m_ready = 1'b1;
    en = 1'b1;
    wait_drain(20, "rf");
    n_checks++; if (word_count !== CW'(4)) begin n_fail++; $display("FAIL rf_refill_count: got %0d required 4", word_count); end
  endtask

  task automatic test_random();
    do_reset(1);
    for (int i = 0; i < 400; i++) begin
      en      = ($urandom_range(0, 3) != 0);
      m_ready = ($urandom_range(0, 2) != 0);
      if (!ffull && $urandom_range(0, 1) == 1) begin
        wr = 1'b1;
        wdata = DW'($urandom);
        exp_q.push_back(wdata);
      end else begin
        wr = 1'b0;
      end
      step();
    end
    wr = 1'b0;
    en = 1'b1;
    m_ready = 1'b1;
    wait_drain(60, "rand");
    n_checks++; if (word_count !== CW'(model_cnt)) begin n_fail++; $display("FAIL rand_count: got %0d required %0d", word_count, model_cnt); end
    n_checks++; if (!fifo_empty)                  begin n_fail++; $display("FAIL rand_fifo_left: fifo_empty=%b required 1", fifo_empty); end
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_stream();
    test_backpressure();
    test_en_drop();
    test_underflow();
    test_reset_full();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
